alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU interface: accepts operation requests over a valid/ready handshake,

---
 rtl/alu_op_sequencer_pkg.sv | 23 ++
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_op_sequencer_flag_reg.sv | 19 +
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operation sequencer: opcode and FSM state enums
// and the bit positions of the {C,N,V,Z} flag word.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } seq_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signals of the sequencer bundled into one interface.
// The master view belongs to the sequencer; the slave view is its environment.
interface alu_op_sequencer_if #(
    parameter int BITS = 3
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [BITS-1:0] req_a_i;
    logic [BITS-1:0] req_b_i;
    logic [1:0]      req_op_i;
    logic [BITS-1:0] alu_a_o;
    logic [BITS-1:0] alu_b_o;
    logic [1:0]      alu_ctrl_o;
    logic [BITS-1:0] alu_s_i;
    logic [3:0]      alu_flags_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [BITS-1:0] rsp_s_o;
    logic [3:0]      rsp_flags_o;
    logic [3:0]      flags_q_o;

    modport master (
        input  req_valid_i, req_a_i, req_b_i, req_op_i, alu_s_i, alu_flags_i, rsp_ready_i,
        output req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, rsp_valid_o, rsp_s_o, rsp_flags_o,
               flags_q_o
    );

    modport slave (
        output req_valid_i, req_a_i, req_b_i, req_op_i, alu_s_i, alu_flags_i, rsp_ready_i,
        input  req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, rsp_valid_o, rsp_s_o, rsp_flags_o,
               flags_q_o
    );
endinterface

// File: rtl/alu_op_sequencer_flag_reg.sv
// Architectural {C,N,V,Z} flag register: loads on enable, cleared by the
// asynchronous active-low reset.
module alu_seq_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'b0000;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the combinational ALU: request -> ISSUE -> response, with a flag register.
// Optional macro ALU_SEQ_ZERO_FLAG_EN recomputes the Z flag from the captured result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BITS = 3
) (
    input logic             clk_i,
    input logic             rst_n_i,
    alu_op_sequencer_if.master bus
);

    seq_state_e      state;
    seq_state_e      next_state;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    alu_op_e         op_q;
    logic [BITS-1:0] s_q;
    logic [3:0]      rsp_flags_q;
    logic [3:0]      cap_flags;
    logic [3:0]      arch_flags;
    logic            load_req;
    logic            capture;
    logic            commit;
    logic            req_ready;
    logic            rsp_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new request can be taken from IDLE or in the same cycle a response is consumed.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        load_req   = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    load_req   = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = bus.rsp_ready_i;
                if (bus.rsp_ready_i) begin
                    commit = 1'b1;
                    if (bus.req_valid_i) begin
                        load_req   = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else if (load_req) begin
            a_q  <= bus.req_a_i;
            b_q  <= bus.req_b_i;
            op_q <= alu_op_e'(bus.req_op_i);
        end
    end

    always_comb begin
        cap_flags = bus.alu_flags_i;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        cap_flags[FLAG_Z] = (bus.alu_s_i == '0);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_q         <= '0;
            rsp_flags_q <= 4'b0000;
        end else if (capture) begin
            s_q         <= bus.alu_s_i;
            rsp_flags_q <= cap_flags;
        end
    end

    alu_seq_flag_reg u_flag_reg (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (commit),
        .d     (rsp_flags_q),
        .q     (arch_flags)
    );

    // ALU buses come straight from the operand registers, so they only move when a request is latched.
    assign bus.alu_a_o     = a_q;
    assign bus.alu_b_o     = b_q;
    assign bus.alu_ctrl_o  = op_q;
    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_s_o     = s_q;
    assign bus.rsp_flags_o = rsp_flags_q;
    assign bus.flags_q_o   = arch_flags;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer at BITS=4 with a behavioural ALU model,
// fixed vector table, hand-written corner sequences and a randomized back-to-back run.
module tb_alu_op_sequencer;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] s;
        logic [3:0] flags;
    } vec_t;

    logic clk;
    logic rst_n;
    logic force_z_low;
    int   checks;
    int   errors;
    logic [3:0] flags_model;
    vec_t vecs[8];

    alu_op_sequencer_if #(.BITS(4)) bus ();

    alu_op_sequencer #(.BITS(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic on plain integers; returns {s, C, N, V, Z}.
    function automatic logic [7:0] ref_op(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        int ia, ib, sa, sb, r, sr;
        logic c, v;
        logic [3:0] s;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'b00: begin
                r  = ia + ib;
                sr = sa + sb;
                c  = (r > 15);
                v  = (sr > 7) || (sr < -8);
            end
            2'b01: begin
                r  = ia - ib;
                sr = sa - sb;
                c  = (ia >= ib);
                v  = (sr > 7) || (sr < -8);
            end
            2'b10:   r = ia << ib;
            default: r = ia >> ib;
        endcase
        s = r[3:0];
        return {s, c, s[3], v, (s == 4'd0)};
    endfunction

    always_comb begin
        logic [7:0] res;
        res             = ref_op(bus.alu_a_o, bus.alu_b_o, bus.alu_ctrl_o);
        bus.alu_s_i     = res[7:4];
        bus.alu_flags_i = res[3:0];
        if (force_z_low) bus.alu_flags_i[0] = 1'b0;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One full transaction from IDLE, checking every phase; leaves the DUT idle.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        check_output("idle_ready", int'(bus.req_ready_o), 1);
        bus.req_valid_i = 1'b1;
        bus.req_a_i     = v.a;
        bus.req_b_i     = v.b;
        bus.req_op_i    = v.op;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check_output("issue_ctrl", int'(bus.alu_ctrl_o), int'(v.op));
        check_output("issue_a", int'(bus.alu_a_o), int'(v.a));
        check_output("issue_b", int'(bus.alu_b_o), int'(v.b));
        check_output("issue_ready", int'(bus.req_ready_o), 0);
        check_output("issue_rsp_valid", int'(bus.rsp_valid_o), 0);
        @(negedge clk);
        check_output("resp_valid", int'(bus.rsp_valid_o), 1);
        check_output("resp_s", int'(bus.rsp_s_o), int'(v.s));
        check_output("resp_flags", int'(bus.rsp_flags_o), int'(v.flags));
        check_output("resp_flags_q_old", int'(bus.flags_q_o), int'(flags_model));
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        flags_model     = v.flags;
        check_output("done_rsp_valid", int'(bus.rsp_valid_o), 0);
        check_output("done_flags_q", int'(bus.flags_q_o), int'(flags_model));
        check_output("hold_ctrl", int'(bus.alu_ctrl_o), int'(v.op));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t zv;
        logic [7:0] q[$];
        logic [7:0] e;
        int n_ops, issued, received, last_cyc;

        checks          = 0;
        errors          = 0;
        flags_model     = 4'b0000;
        force_z_low     = 1'b0;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_a_i     = 4'd0;
        bus.req_b_i     = 4'd0;
        bus.req_op_i    = 2'b00;
        bus.rsp_ready_i = 1'b0;

        // {a, b, op, s, {C,N,V,Z}}
        vecs[0] = '{4'd3,  4'd4, 2'b00, 4'b0111, 4'b0000};
        vecs[1] = '{4'd8,  4'd1, 2'b01, 4'b0111, 4'b1010};
        vecs[2] = '{4'd3,  4'd1, 2'b10, 4'b0110, 4'b0000};
        vecs[3] = '{4'd8,  4'd3, 2'b11, 4'b0001, 4'b0000};
        vecs[4] = '{4'd15, 4'd1, 2'b00, 4'b0000, 4'b1001};
        vecs[5] = '{4'd7,  4'd1, 2'b00, 4'b1000, 4'b0110};
        vecs[6] = '{4'd3,  4'd5, 2'b01, 4'b1110, 4'b0100};
        vecs[7] = '{4'd1,  4'd5, 2'b10, 4'b0000, 4'b0001};

        @(negedge clk);
        @(negedge clk);
        check_output("rst_req_ready", int'(bus.req_ready_o), 1);
        check_output("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
        check_output("rst_alu_a", int'(bus.alu_a_o), 0);
        check_output("rst_alu_b", int'(bus.alu_b_o), 0);
        check_output("rst_alu_ctrl", int'(bus.alu_ctrl_o), 0);
        check_output("rst_rsp_s", int'(bus.rsp_s_o), 0);
        check_output("rst_flags_q", int'(bus.flags_q_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

        // Stalled consumer: response and flag register must hold, new requests ignored.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_a_i     = 4'd2;
        bus.req_b_i     = 4'd3;
        bus.req_op_i    = 2'b00;
        @(negedge clk);
        bus.req_a_i  = 4'd9;
        bus.req_b_i  = 4'd9;
        bus.req_op_i = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_valid", int'(bus.rsp_valid_o), 1);
            check_output("stall_s", int'(bus.rsp_s_o), 5);
            check_output("stall_flags", int'(bus.rsp_flags_o), 0);
            check_output("stall_ready", int'(bus.req_ready_o), 0);
            check_output("stall_flags_q", int'(bus.flags_q_o), int'(flags_model));
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        flags_model     = 4'b0000;
        check_output("stall_done_flags_q", int'(bus.flags_q_o), 0);
        check_output("stall_done_valid", int'(bus.rsp_valid_o), 0);
        check_output("stall_ignored_a", int'(bus.alu_a_o), 2);

        // ALU reports Z=0 on a zero result; only the zero-flag build corrects it.
        force_z_low = 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zv = '{4'd5, 4'd5, 2'b01, 4'b0000, 4'b1001};
`else
        zv = '{4'd5, 4'd5, 2'b01, 4'b0000, 4'b1000};
`endif
        apply_stimulus(zv);
        force_z_low = 1'b0;

        // Randomized back-to-back run, responses consumed immediately.
        n_ops    = 24;
        issued   = 0;
        received = 0;
        last_cyc = -1;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && received < n_ops; cyc++) begin
            check_output("b2b_flags_q", int'(bus.flags_q_o), int'(flags_model));
            if (bus.rsp_valid_o) begin
                if (q.size() == 0) begin
                    check_output("b2b_unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_output("b2b_s", int'(bus.rsp_s_o), int'(e[7:4]));
                    check_output("b2b_flags", int'(bus.rsp_flags_o), int'(e[3:0]));
                    flags_model = e[3:0];
                end
                if (last_cyc >= 0) check_output("b2b_interval", cyc - last_cyc, 2);
                last_cyc = cyc;
                received++;
            end
            if (issued < n_ops) begin
                bus.req_valid_i = 1'b1;
                bus.req_a_i     = 4'($urandom_range(0, 15));
                bus.req_b_i     = 4'($urandom_range(0, 15));
                bus.req_op_i    = 2'($urandom_range(0, 3));
                if (bus.req_ready_o) begin
                    q.push_back(ref_op(bus.req_a_i, bus.req_b_i, bus.req_op_i));
                    issued++;
                end
            end else begin
                bus.req_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        check_output("b2b_count", received, n_ops);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check_output("b2b_final_flags_q", int'(bus.flags_q_o), int'(flags_model));
        check_output("b2b_final_valid", int'(bus.rsp_valid_o), 0);

        // Reset while an operation is in ISSUE.
        apply_stimulus(vecs[1]);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_a_i     = 4'd3;
        bus.req_b_i     = 4'd4;
        bus.req_op_i    = 2'b00;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("midrst_rsp_valid", int'(bus.rsp_valid_o), 0);
        check_output("midrst_flags_q", int'(bus.flags_q_o), 0);
        check_output("midrst_req_ready", int'(bus.req_ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("postrst_req_ready", int'(bus.req_ready_o), 1);
        check_output("postrst_rsp_valid", int'(bus.rsp_valid_o), 0);
        check_output("postrst_flags_q", int'(bus.flags_q_o), 0);
        check_output("postrst_alu_a", int'(bus.alu_a_o), 0);
        flags_model = 4'b0000;
        apply_stimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
